// File: rtl/decode_stage.sv
// Decode stage: field split, 8x16 register file with write-through read,
// RAW hazard detection against the ALU-stage destination, bubble insertion.
module decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] inst,
    input  logic        inst_valid,
    output logic        inst_ready,
    input  logic [15:0] wb_data,
    input  logic [2:0]  wb_adr,
    input  logic        wb_we,
    output logic [15:0] regA,
    output logic [15:0] regB,
    output logic [3:0]  cop,
    output logic [2:0]  destReg_adr,
    output logic        we,
    output logic [2:0]  regA_adr,
    output logic [2:0]  regB_adr,
    output logic [2:0]  inst_freeBits,
    output logic [15:0] hazard_cnt
);

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  cop;
        logic [2:0]  dest;
        logic        we;
        logic [2:0]  sa;
        logic [2:0]  sb;
        logic [2:0]  free;
    } id_ex_t;

    logic [15:0] rf_q [8];
    id_ex_t      out_q, out_d;
    logic [15:0] hcnt_q, hcnt_d;

    logic [3:0]  f_cop;
    logic [2:0]  f_dest, f_sa, f_sb, f_free;
    logic        is_nop, hazard;
    logic [15:0] rd_a, rd_b;

    assign f_cop  = inst[15:12];
    assign f_dest = inst[11:9];
    assign f_sa   = inst[8:6];
    assign f_sb   = inst[5:3];
    assign f_free = inst[2:0];
    assign is_nop = (f_cop == 4'd0);

    // RAW on the instruction currently held in the ALU-stage registers
    always_comb begin
        hazard = 1'b0;
        if (inst_valid && !is_nop && out_q.we) begin
            hazard = (f_sa == out_q.dest) || (f_sb == out_q.dest);
        end
    end

    assign inst_ready = enable && inst_valid && !hazard && !reset;

    // Operand read with same-cycle writeback forwarding
    always_comb begin
        rd_a = rf_q[f_sa];
        rd_b = rf_q[f_sb];
        if (wb_we && (wb_adr == f_sa)) rd_a = wb_data;
        if (wb_we && (wb_adr == f_sb)) rd_b = wb_data;
    end

    // Next state for ALU-stage registers and the hazard counter
    always_comb begin
        out_d  = out_q;
        hcnt_d = hcnt_q;
        if (enable) begin
            if (inst_ready) begin
                out_d.a    = rd_a;
                out_d.b    = rd_b;
                out_d.cop  = f_cop;
                out_d.dest = f_dest;
                out_d.we   = !is_nop;
                out_d.sa   = f_sa;
                out_d.sb   = f_sb;
                out_d.free = f_free;
            end else begin
                out_d = '0;
            end
            if (hazard && (hcnt_q != 16'hFFFF)) begin
                hcnt_d = hcnt_q + 16'd1;
            end
        end
    end

    // Pipeline registers and counter, reset has priority
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q  <= '0;
            hcnt_q <= '0;
        end else begin
            out_q  <= out_d;
            hcnt_q <= hcnt_d;
        end
    end

    // Register file write port, independent of enable
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
        end else if (wb_we) begin
            rf_q[wb_adr] <= wb_data;
        end
    end

    assign regA          = out_q.a;
    assign regB          = out_q.b;
    assign cop           = out_q.cop;
    assign destReg_adr   = out_q.dest;
    assign we            = out_q.we;
    assign regA_adr      = out_q.sa;
    assign regB_adr      = out_q.sb;
    assign inst_freeBits = out_q.free;
    assign hazard_cnt    = hcnt_q;

endmodule
